// File: rtl/instr_queue_pkg.sv
// iq_pkg: shared constants, pointer-width helper and packed entry type for instr_queue (no ports)
package iq_pkg;
  localparam logic [31:0] ARM_NOP = 32'hE1A00000;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
  } iq_entry_t;
  function automatic int iq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/instr_queue_if.sv
// instr_queue_if: fetch/decode bus; master=fetch+decode side (flush, in_valid/in_instr/in_pc8, out_ready), slave=queue (in_ready, out_valid/out_instr/out_pc8, count)
interface instr_queue_if #(
  parameter int WIDTH = 32,
  parameter int PCW = 32,
  parameter int DEPTH = 4
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_instr;
  logic [PCW-1:0] in_pc8;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [PCW-1:0] out_pc8;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (
    output flush, in_valid, in_instr, in_pc8, out_ready,
    input in_ready, out_valid, out_instr, out_pc8, count
  );
  modport slave (
    input flush, in_valid, in_instr, in_pc8, out_ready,
    output in_ready, out_valid, out_instr, out_pc8, count
  );
endinterface

// File: rtl/instr_queue_storage.sv
// iq_storage: unreset DEPTH x W register array; ports clk, we/waddr/wdata write port, raddr/rdata async read port
module iq_storage #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_queue.sv
// instr_queue: fetch-to-decode circular instruction buffer; ports clk, reset (async high), bus (instr_queue_if.slave); optional same-cycle bypass when empty via IQ_BYPASS_EN
module instr_queue
  import iq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PCW = 32,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(ARM_NOP)
) (
  input logic clk,
  input logic reset,
  instr_queue_if.slave bus
);
  localparam int PW = iq_ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic empty, full, byp, push, pop, wr_en, rd_adv;
  logic [WIDTH+PCW-1:0] head;
  assign empty = rd_ptr == wr_ptr;
  assign full = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
`ifdef IQ_BYPASS_EN
  assign byp = empty & bus.in_valid & !bus.flush;
`else
  assign byp = 1'b0;
`endif
  assign bus.in_ready = !full & !bus.flush;
  assign bus.out_valid = (!empty | byp) & !bus.flush;
  assign push = bus.in_valid & bus.in_ready;
  assign pop = bus.out_valid & bus.out_ready;
  // a bypassed word that decode takes immediately never touches storage
  assign wr_en = push & !(byp & bus.out_ready);
  assign rd_adv = pop & !empty;
  iq_storage #(.DEPTH(DEPTH), .W(WIDTH + PCW)) u_storage (
    .clk(clk),
    .we(wr_en),
    .waddr(wr_ptr[AW-1:0]),
    .wdata({bus.in_instr, bus.in_pc8}),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(head)
  );
  assign bus.out_instr = !bus.out_valid ? NOP_INSTR : byp ? bus.in_instr : head[WIDTH+PCW-1:PCW];
  assign bus.out_pc8 = !bus.out_valid ? '0 : byp ? bus.in_pc8 : head[PCW-1:0];
  assign bus.count = cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(rd_adv);
      wr_ptr <= wr_ptr + PW'(wr_en);
      cnt <= cnt + CW'(wr_en) - CW'(rd_adv);
    end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed self-checking bench for instr_queue (DEPTH=4)
module tb_instr_queue;
  logic clk = 0;
  logic reset = 1;
  int total = 0;
  int bad = 0;
  localparam logic [31:0] NOP = 32'hE1A00000;
  instr_queue_if #(.WIDTH(32), .PCW(32), .DEPTH(4)) bus ();
  instr_queue #(.WIDTH(32), .PCW(32), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_ovalid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_instr"}, 64'(bus.out_instr), 64'(NOP));
    chk({tag, "_pc8"}, 64'(bus.out_pc8), 64'd0);
    chk({tag, "_iready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_count"}, 64'(bus.count), 64'd0);
  endtask
  initial begin
    bus.flush = 0;
    bus.in_valid = 0;
    bus.in_instr = 0;
    bus.in_pc8 = 0;
    bus.out_ready = 0;
    #3;
    chk_idle("reset");
    tick();
    tick();
    reset = 0;
    #1;
    chk_idle("idle");
    bus.in_valid = 1;
    bus.in_instr = 32'hE3A01005;
    bus.in_pc8 = 32'h08;
    tick();
    bus.in_instr = 32'hE2811001;
    bus.in_pc8 = 32'h0C;
    tick();
    bus.in_valid = 0;
    #1;
    chk("two_count", 64'(bus.count), 64'd2);
    chk("two_head", 64'(bus.out_instr), 64'hE3A01005);
    chk("two_pc8", 64'(bus.out_pc8), 64'h08);
    bus.out_ready = 1;
    tick();
    chk("pop1_head", 64'(bus.out_instr), 64'hE2811001);
    chk("pop1_pc8", 64'(bus.out_pc8), 64'h0C);
    chk("pop1_count", 64'(bus.count), 64'd1);
    tick();
    chk("pop2_valid", 64'(bus.out_valid), 64'd0);
    chk("pop2_instr", 64'(bus.out_instr), 64'(NOP));
    chk("pop2_count", 64'(bus.count), 64'd0);
    bus.out_ready = 0;
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1;
      for (int i = 0; i < 4; i++) begin
        bus.in_instr = 32'h1000_0000 + 32'(b * 4 + i);
        bus.in_pc8 = 32'(4 * (b * 4 + i));
        tick();
      end
      bus.in_instr = 32'h0000_0BAD;
      #1;
      chk("full_iready", 64'(bus.in_ready), 64'd0);
      chk("full_count", 64'(bus.count), 64'd4);
      bus.out_ready = 1;
      #1;
      chk("full_pop_iready", 64'(bus.in_ready), 64'd0);
      tick();
      bus.in_valid = 0;
      for (int i = 1; i < 4; i++) begin
        #1;
        chk("drain_instr", 64'(bus.out_instr), 64'h1000_0000 + 64'(b * 4 + i));
        chk("drain_pc8", 64'(bus.out_pc8), 64'(4 * (b * 4 + i)));
        tick();
      end
      chk("drain_empty", 64'(bus.out_valid), 64'd0);
      chk("drain_count", 64'(bus.count), 64'd0);
      bus.out_ready = 0;
    end
    bus.in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      bus.in_instr = 32'hA000_0000 + 32'(i);
      bus.in_pc8 = 32'(i);
      tick();
    end
    bus.out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      bus.in_instr = 32'hA000_0000 + 32'(k + 2);
      bus.in_pc8 = 32'(k + 2);
      #1;
      chk("pp_head", 64'(bus.out_instr), 64'hA000_0000 + 64'(k));
      chk("pp_count", 64'(bus.count), 64'd2);
      tick();
    end
    bus.in_valid = 0;
    chk("pp_tail0", 64'(bus.out_instr), 64'hA000_0005);
    tick();
    chk("pp_tail1", 64'(bus.out_instr), 64'hA000_0006);
    tick();
    chk("pp_end", 64'(bus.count), 64'd0);
    bus.out_ready = 0;
    bus.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.in_instr = 32'hC000_0000 + 32'(i);
      tick();
    end
    bus.in_instr = 32'hDEAD_BEEF;
    bus.flush = 1;
    #1;
    chk("flush_ovalid", 64'(bus.out_valid), 64'd0);
    chk("flush_iready", 64'(bus.in_ready), 64'd0);
    chk("flush_instr", 64'(bus.out_instr), 64'(NOP));
    tick();
    bus.flush = 0;
    bus.in_valid = 0;
    #1;
    chk("postflush_count", 64'(bus.count), 64'd0);
    chk("postflush_ovalid", 64'(bus.out_valid), 64'd0);
    bus.in_valid = 1;
    bus.in_instr = 32'hE1000001;
    tick();
    bus.in_valid = 0;
    chk("postflush_head", 64'(bus.out_instr), 64'hE1000001);
    chk("postflush_count1", 64'(bus.count), 64'd1);
    bus.out_ready = 1;
    tick();
    chk("postflush_drain", 64'(bus.count), 64'd0);
    bus.in_valid = 1;
    bus.in_instr = 32'hE0821003;
    bus.in_pc8 = 32'h20;
    #1;
`ifdef IQ_BYPASS_EN
    chk("byp_ovalid", 64'(bus.out_valid), 64'd1);
    chk("byp_instr", 64'(bus.out_instr), 64'hE0821003);
    chk("byp_pc8", 64'(bus.out_pc8), 64'h20);
    tick();
    bus.in_valid = 0;
    #1;
    chk("byp_count", 64'(bus.count), 64'd0);
    chk("byp_after", 64'(bus.out_valid), 64'd0);
`else
    chk("nobyp_ovalid", 64'(bus.out_valid), 64'd0);
    chk("nobyp_instr", 64'(bus.out_instr), 64'(NOP));
    tick();
    bus.in_valid = 0;
    #1;
    chk("nobyp_late", 64'(bus.out_instr), 64'hE0821003);
    chk("nobyp_count", 64'(bus.count), 64'd1);
    tick();
    chk("nobyp_drain", 64'(bus.count), 64'd0);
`endif
    bus.out_ready = 0;
    bus.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.in_instr = 32'hF000_0000 + 32'(i);
      bus.in_pc8 = 32'h100 + 32'(i);
      tick();
    end
    bus.in_valid = 0;
    chk("mid_count", 64'(bus.count), 64'd3);
    chk("mid_ovalid", 64'(bus.out_valid), 64'd1);
    reset = 1;
    #1;
    chk_idle("async_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
